// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: exec->mem and mem->wb bundles, PC source
// encoding, the memory-stage FSM encoding and small datapath helpers.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BEQ  = 3'd1,
        BNE  = 3'd2,
        JUMP = 3'd3,
        JR   = 3'd4
    } pcsrc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } memstage_state_t;

    typedef struct packed {
        logic              halt;
        logic [REG_AW-1:0] wsel;
        logic              RegWr;
        logic              MemToReg;
        logic              WrLinkReg;
        logic              MemRd;
        logic              MemWr;
        pcsrc_t            PCSrc;
        logic [WORD_W-1:0] aluOut;
        logic              zero;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] b_addr;
        logic [WORD_W-1:0] j_addr;
        logic [WORD_W-1:0] pc;
        logic              pred_taken;
    } exec_mem_t;

    typedef struct packed {
        logic              halt;
        logic [REG_AW-1:0] wsel;
        logic              RegWr;
        logic [WORD_W-1:0] wdat;
    } mem_wb_t;

    // Writeback context kept while a data-cache access is outstanding.
    typedef struct packed {
        logic [REG_AW-1:0] wsel;
        logic              RegWr;
        logic              MemToReg;
        logic              WrLinkReg;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] aluOut;
    } acc_ctx_t;

    // Sequential PC; wraps modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(3'd4);
    endfunction

    // Writeback data selection: load data, link address, or ALU result.
    function automatic logic [WORD_W-1:0] writeback_data(
        input logic              mem_to_reg,
        input logic              wr_link,
        input logic [WORD_W-1:0] pc,
        input logic [WORD_W-1:0] alu_out,
        input logic [WORD_W-1:0] load_data
    );
        logic [WORD_W-1:0] res;
        if (mem_to_reg) begin
            res = load_data;
        end else if (wr_link) begin
            res = pc_plus4(pc);
        end else begin
            res = alu_out;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Memory-stage bus bundle: exec input, data-cache request/response,
// redirect, predictor update and writeback output.
interface mem_stage_if
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = WORD_W
) ();

    logic              in_valid;
    exec_mem_t         in;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    logic              dREN;
    logic              dWEN;
    logic [DATA_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] npc;
    logic              bp_upd;
    logic [DATA_W-1:0] bp_pc;
    logic              bp_taken;
    logic              out_valid;
    mem_wb_t           out;

    // Memory stage side
    modport master (
        input  in_valid, in, dhit, dmemload,
        output dREN, dWEN, dmemaddr, dmemstore, stall, flush, npc,
               bp_upd, bp_pc, bp_taken, out_valid, out
    );

    // Pipeline / cache environment side
    modport slave (
        output in_valid, in, dhit, dmemload,
        input  dREN, dWEN, dmemaddr, dmemstore, stall, flush, npc,
               bp_upd, bp_pc, bp_taken, out_valid, out
    );

endinterface

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution: outcome, redirect decision and
// the redirect target for the op presented to the memory stage.
module branch_resolve
    import cpu_types_pkg::*;
(
    input  pcsrc_t            pcsrc_i,
    input  logic              zero_i,
    input  logic              pred_taken_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] b_addr_i,
    input  logic [WORD_W-1:0] j_addr_i,
    input  logic [WORD_W-1:0] rdat1_i,
    output logic              taken_o,
    output logic              is_cond_o,
    output logic              redirect_o,
    output logic [WORD_W-1:0] npc_o
);

    logic [WORD_W-1:0] target_s;

    // Decode the control-flow class and pick the taken target
    always_comb begin
        taken_o   = 1'b0;
        is_cond_o = 1'b0;
        target_s  = pc_plus4(pc_i);
        case (pcsrc_i)
            SEQ: begin
                taken_o  = 1'b0;
                target_s = pc_plus4(pc_i);
            end
            BEQ: begin
                is_cond_o = 1'b1;
                taken_o   = zero_i;
                target_s  = b_addr_i;
            end
            BNE: begin
                is_cond_o = 1'b1;
                taken_o   = !zero_i;
                target_s  = b_addr_i;
            end
            JUMP: begin
                taken_o  = 1'b1;
                target_s = j_addr_i;
            end
            JR: begin
                taken_o  = 1'b1;
                target_s = rdat1_i;
            end
            default: begin
                taken_o  = 1'b0;
                target_s = pc_plus4(pc_i);
            end
        endcase
    end

    // Jumps always redirect; branches only when the prediction was wrong
    always_comb begin
        redirect_o = 1'b0;
        if ((pcsrc_i == JUMP) || (pcsrc_i == JR)) begin
            redirect_o = 1'b1;
        end else if (is_cond_o) begin
            redirect_o = taken_o ^ pred_taken_i;
        end else begin
            redirect_o = 1'b0;
        end
        npc_o = taken_o ? target_s : pc_plus4(pc_i);
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues registered data-cache requests, resolves
// control flow, updates the branch predictor and produces writeback results.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic        CLK,
    input  logic        RST,
    mem_stage_if.master bus
);

    memstage_state_t   state_q, state_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic              bp_upd_q, bp_upd_d;
    logic [DATA_W-1:0] bp_pc_q, bp_pc_d;
    logic              bp_taken_q, bp_taken_d;
    logic              out_valid_q, out_valid_d;
    mem_wb_t           out_q, out_d;
    acc_ctx_t          acc_q, acc_d;
    // A result accepted in the same cycle a load/store retires is held one
    // cycle here so the single writeback port never carries two results.
    logic              pend_q, pend_d;
    mem_wb_t           pend_out_q, pend_out_d;

    logic              accept_s;
    logic              stall_s;
    logic              is_mem_s;
    mem_wb_t           new_wb_s;
    logic              br_taken_s;
    logic              br_cond_s;
    logic              br_redirect_s;
    logic [WORD_W-1:0] br_npc_s;

    branch_resolve u_branch_resolve (
        .pcsrc_i      (bus.in.PCSrc),
        .zero_i       (bus.in.zero),
        .pred_taken_i (bus.in.pred_taken),
        .pc_i         (bus.in.pc),
        .b_addr_i     (bus.in.b_addr),
        .j_addr_i     (bus.in.j_addr),
        .rdat1_i      (bus.in.rdat1),
        .taken_o      (br_taken_s),
        .is_cond_o    (br_cond_s),
        .redirect_o   (br_redirect_s),
        .npc_o        (br_npc_s)
    );

    // Acceptance and upstream back-pressure from the current state
    always_comb begin
        accept_s = 1'b0;
        stall_s  = 1'b0;
        case (state_q)
            IDLE: begin
                accept_s = bus.in_valid && !flush_q && !pend_q;
                stall_s  = pend_q;
            end
            ACCESS: begin
                accept_s = bus.in_valid && !flush_q && bus.dhit;
                stall_s  = !bus.dhit;
            end
            HALTED: begin
                accept_s = 1'b0;
                stall_s  = 1'b1;
            end
            default: begin
                accept_s = 1'b0;
                stall_s  = 1'b0;
            end
        endcase
    end

    // Next-state, request, redirect and writeback sequencing
    always_comb begin
        state_d     = state_q;
        dren_d      = dren_q;
        dwen_d      = dwen_q;
        addr_d      = addr_q;
        store_d     = store_q;
        flush_d     = 1'b0;
        npc_d       = npc_q;
        bp_upd_d    = 1'b0;
        bp_pc_d     = bp_pc_q;
        bp_taken_d  = bp_taken_q;
        out_valid_d = 1'b0;
        out_d       = out_q;
        acc_d       = acc_q;
        pend_d      = 1'b0;
        pend_out_d  = pend_out_q;
        is_mem_s    = bus.in.MemRd || bus.in.MemWr;
        new_wb_s    = '{halt:  bus.in.halt,
                        wsel:  bus.in.wsel,
                        RegWr: bus.in.RegWr,
                        wdat:  writeback_data(bus.in.MemToReg, bus.in.WrLinkReg,
                                              bus.in.pc, bus.in.aluOut, bus.dmemload)};

        // Retire the outstanding access, or release a held result
        if ((state_q == ACCESS) && bus.dhit) begin
            state_d     = IDLE;
            dren_d      = 1'b0;
            dwen_d      = 1'b0;
            out_valid_d = 1'b1;
            out_d       = '{halt:  1'b0,
                            wsel:  acc_q.wsel,
                            RegWr: acc_q.RegWr,
                            wdat:  writeback_data(acc_q.MemToReg, acc_q.WrLinkReg,
                                                  acc_q.pc, acc_q.aluOut, bus.dmemload)};
        end else if (pend_q) begin
            out_valid_d = 1'b1;
            out_d       = pend_out_q;
        end else begin
            out_valid_d = 1'b0;
        end

        if (accept_s) begin
            flush_d  = br_redirect_s;
            npc_d    = br_redirect_s ? br_npc_s : npc_q;
            bp_upd_d = br_cond_s;
            if (br_cond_s) begin
                bp_pc_d    = bus.in.pc;
                bp_taken_d = br_taken_s;
            end else begin
                bp_pc_d    = bp_pc_q;
                bp_taken_d = bp_taken_q;
            end
            if (!bus.in.halt && is_mem_s) begin
                state_d = ACCESS;
                dren_d  = bus.in.MemRd;
                dwen_d  = bus.in.MemWr;
                addr_d  = bus.in.aluOut;
                store_d = bus.in.rdat2;
                acc_d   = '{wsel:      bus.in.wsel,
                            RegWr:     bus.in.RegWr,
                            MemToReg:  bus.in.MemToReg,
                            WrLinkReg: bus.in.WrLinkReg,
                            pc:        bus.in.pc,
                            aluOut:    bus.in.aluOut};
            end else begin
                state_d = bus.in.halt ? HALTED : IDLE;
                if (out_valid_d) begin
                    pend_d     = 1'b1;
                    pend_out_d = new_wb_s;
                end else begin
                    out_valid_d = 1'b1;
                    out_d       = new_wb_s;
                end
            end
        end else begin
            flush_d  = 1'b0;
            bp_upd_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            addr_q      <= '0;
            store_q     <= '0;
            flush_q     <= 1'b0;
            npc_q       <= '0;
            bp_upd_q    <= 1'b0;
            bp_pc_q     <= '0;
            bp_taken_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            acc_q       <= '0;
            pend_q      <= 1'b0;
            pend_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            dren_q      <= dren_d;
            dwen_q      <= dwen_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            flush_q     <= flush_d;
            npc_q       <= npc_d;
            bp_upd_q    <= bp_upd_d;
            bp_pc_q     <= bp_pc_d;
            bp_taken_q  <= bp_taken_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            pend_out_q  <= pend_out_d;
        end
    end

    // Drive the bus from the registered state
    assign bus.dREN      = dren_q;
    assign bus.dWEN      = dwen_q;
    assign bus.dmemaddr  = addr_q;
    assign bus.dmemstore = store_q;
    assign bus.stall     = stall_s;
    assign bus.flush     = flush_q;
    assign bus.npc       = npc_q;
    assign bus.bp_upd    = bp_upd_q;
    assign bus.bp_pc     = bp_pc_q;
    assign bus.bp_taken  = bp_taken_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage: directed ops push expected writeback
// results; an independent monitor pops and compares on every out_valid.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    mem_wb_t exp_q[$];
    mem_wb_t mon_e;

    mem_stage_if #(.DATA_W(32)) bus ();

    mem_stage #(.DATA_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mem_wb_t mk_wb(input logic h, input logic [4:0] w,
                                      input logic rw, input logic [31:0] d);
        mem_wb_t r;
        r.halt = h; r.wsel = w; r.RegWr = rw; r.wdat = d;
        return r;
    endfunction

    task automatic drive(input exec_mem_t op);
        bus.in       = op;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in       = '0;
    endtask

    // Scoreboard monitor: each writeback pulse must match the oldest expectation
    always @(negedge CLK) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got out_valid=1 wdat=%0h expected no result", bus.out.wdat);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_halt",  64'(bus.out.halt),  64'(mon_e.halt));
                chk("wb_wsel",  64'(bus.out.wsel),  64'(mon_e.wsel));
                chk("wb_regwr", 64'(bus.out.RegWr), 64'(mon_e.RegWr));
                chk("wb_wdat",  64'(bus.out.wdat),  64'(mon_e.wdat));
            end
        end
    end

    // Directed stimulus
    initial begin
        exec_mem_t op;
        RST = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = '0;
        bus.dhit     = 1'b0;
        bus.dmemload = 32'h0;
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst_dren",      64'(bus.dREN),      64'd0);
        chk("rst_dwen",      64'(bus.dWEN),      64'd0);
        chk("rst_stall",     64'(bus.stall),     64'd0);
        chk("rst_flush",     64'(bus.flush),     64'd0);
        chk("rst_bp_upd",    64'(bus.bp_upd),    64'd0);
        chk("rst_bp_taken",  64'(bus.bp_taken),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_dmemaddr",  64'(bus.dmemaddr),  64'd0);
        chk("rst_dmemstore", 64'(bus.dmemstore), 64'd0);
        chk("rst_npc",       64'(bus.npc),       64'd0);
        chk("rst_bp_pc",     64'(bus.bp_pc),     64'd0);
        chk("rst_out",       64'(bus.out),       64'd0);
        RST = 1'b0;

        // ALU op: result one cycle later, never stalls
        op = '0; op.aluOut = 32'h10; op.RegWr = 1'b1; op.wsel = 5'd5;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd5, 1'b1, 32'h10));
        chk("alu_stall_a", 64'(bus.stall), 64'd0);
        @(negedge CLK); idle();
        chk("alu_out_valid", 64'(bus.out_valid), 64'd1);
        chk("alu_stall_b",   64'(bus.stall),     64'd0);
        @(negedge CLK);
        chk("alu_pulse_end", 64'(bus.out_valid), 64'd0);

        // Load with dhit on the third access cycle
        op = '0; op.aluOut = 32'h100; op.MemRd = 1'b1; op.MemToReg = 1'b1;
        op.RegWr = 1'b1; op.wsel = 5'd7;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd7, 1'b1, 32'hDEADBEEF));
        @(negedge CLK); idle();
        chk("ld_dren_1",    64'(bus.dREN),     64'd1);
        chk("ld_addr",      64'(bus.dmemaddr), 64'h100);
        chk("ld_stall_1",   64'(bus.stall),    64'd1);
        @(negedge CLK);
        chk("ld_dren_2",    64'(bus.dREN),      64'd1);
        chk("ld_stall_2",   64'(bus.stall),     64'd1);
        chk("ld_no_out",    64'(bus.out_valid), 64'd0);
        @(negedge CLK);
        chk("ld_dren_3",    64'(bus.dREN), 64'd1);
        bus.dhit = 1'b1; bus.dmemload = 32'hDEADBEEF;
        #1;
        chk("ld_stall_hit", 64'(bus.stall), 64'd0);
        @(negedge CLK);
        bus.dhit = 1'b0; bus.dmemload = 32'h0;
        chk("ld_dren_drop", 64'(bus.dREN),      64'd0);
        chk("ld_out_valid", 64'(bus.out_valid), 64'd1);

        // BEQ taken, predicted not taken: redirect and drop the next op
        @(negedge CLK);
        op = '0; op.PCSrc = BEQ; op.zero = 1'b1; op.pred_taken = 1'b0;
        op.b_addr = 32'h40; op.pc = 32'h30;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd0, 1'b0, 32'h0));
        @(negedge CLK);
        chk("beq_flush",    64'(bus.flush),    64'd1);
        chk("beq_npc",      64'(bus.npc),      64'h40);
        chk("beq_bp_upd",   64'(bus.bp_upd),   64'd1);
        chk("beq_bp_taken", 64'(bus.bp_taken), 64'd1);
        chk("beq_bp_pc",    64'(bus.bp_pc),    64'h30);
        op = '0; op.aluOut = 32'h55; op.RegWr = 1'b1; op.wsel = 5'd3;
        drive(op);
        @(negedge CLK); idle();
        chk("beq_flush_end", 64'(bus.flush),     64'd0);
        chk("beq_dropped",   64'(bus.out_valid), 64'd0);

        // JAL: redirect to j_addr, link pc+4
        op = '0; op.PCSrc = JUMP; op.pc = 32'h20; op.j_addr = 32'h80;
        op.WrLinkReg = 1'b1; op.RegWr = 1'b1; op.wsel = 5'd31; op.aluOut = 32'h999;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd31, 1'b1, 32'h24));
        @(negedge CLK); idle();
        chk("jal_flush",  64'(bus.flush),  64'd1);
        chk("jal_npc",    64'(bus.npc),    64'h80);
        chk("jal_bp_upd", 64'(bus.bp_upd), 64'd0);
        @(negedge CLK);
        // BNE not taken, predicted not taken: update only
        op = '0; op.PCSrc = BNE; op.zero = 1'b1; op.pred_taken = 1'b0;
        op.pc = 32'h60; op.b_addr = 32'h90; op.aluOut = 32'h7;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd0, 1'b0, 32'h7));
        @(negedge CLK);
        chk("bne_flush",    64'(bus.flush),    64'd0);
        chk("bne_bp_upd",   64'(bus.bp_upd),   64'd1);
        chk("bne_bp_taken", 64'(bus.bp_taken), 64'd0);
        chk("bne_bp_pc",    64'(bus.bp_pc),    64'h60);
        chk("bne_npc_hold", 64'(bus.npc),      64'h80);
        // BNE not taken but predicted taken: redirect to pc+4
        op = '0; op.PCSrc = BNE; op.zero = 1'b1; op.pred_taken = 1'b1;
        op.pc = 32'h70; op.b_addr = 32'hA0;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd0, 1'b0, 32'h0));
        @(negedge CLK); idle();
        chk("bne_mp_flush", 64'(bus.flush), 64'd1);
        chk("bne_mp_npc",   64'(bus.npc),   64'h74);
        chk("bne_mp_bp_pc", 64'(bus.bp_pc), 64'h70);
        @(negedge CLK);
        // JR: redirect to rdat1
        op = '0; op.PCSrc = JR; op.rdat1 = 32'h200; op.pc = 32'h10;
        op.aluOut = 32'h11; op.RegWr = 1'b1; op.wsel = 5'd4;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd4, 1'b1, 32'h11));
        @(negedge CLK); idle();
        chk("jr_flush", 64'(bus.flush), 64'd1);
        chk("jr_npc",   64'(bus.npc),   64'h200);
        @(negedge CLK);
        // Link address wraps at the top of the address space
        op = '0; op.WrLinkReg = 1'b1; op.RegWr = 1'b1; op.wsel = 5'd31;
        op.pc = 32'hFFFFFFFC; op.aluOut = 32'h5;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd31, 1'b1, 32'h0));
        @(negedge CLK); idle();
        chk("wrap_flush", 64'(bus.flush), 64'd0);
        @(negedge CLK);

        // Reset in the middle of a load abandons it
        op = '0; op.aluOut = 32'h300; op.MemRd = 1'b1; op.MemToReg = 1'b1;
        op.RegWr = 1'b1; op.wsel = 5'd9;
        drive(op);
        @(negedge CLK); idle();
        chk("rl_dren", 64'(bus.dREN), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rl_dren_drop", 64'(bus.dREN),      64'd0);
        chk("rl_stall",     64'(bus.stall),     64'd0);
        chk("rl_no_out_a",  64'(bus.out_valid), 64'd0);
        bus.dhit = 1'b1; bus.dmemload = 32'h1234;
        @(negedge CLK);
        bus.dhit = 1'b0; bus.dmemload = 32'h0;
        chk("rl_no_out_b", 64'(bus.out_valid), 64'd0);
        chk("rl_dren_off", 64'(bus.dREN),      64'd0);
        op = '0; op.aluOut = 32'h77; op.RegWr = 1'b1; op.wsel = 5'd2;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd2, 1'b1, 32'h77));
        @(negedge CLK); idle();
        chk("rl_next_op", 64'(bus.out_valid), 64'd1);
        @(negedge CLK);

        // Store followed immediately by halt
        op = '0; op.MemWr = 1'b1; op.aluOut = 32'h104; op.rdat2 = 32'hCAFEF00D;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd0, 1'b0, 32'h104));
        @(negedge CLK);
        chk("st_dwen_1",  64'(bus.dWEN),      64'd1);
        chk("st_dren",    64'(bus.dREN),      64'd0);
        chk("st_addr",    64'(bus.dmemaddr),  64'h104);
        chk("st_data",    64'(bus.dmemstore), 64'hCAFEF00D);
        chk("st_stall_1", 64'(bus.stall),     64'd1);
        op = '0; op.halt = 1'b1;
        drive(op);
        @(negedge CLK);
        chk("st_dwen_2",  64'(bus.dWEN),      64'd1);
        chk("st_stall_2", 64'(bus.stall),     64'd1);
        chk("st_no_out",  64'(bus.out_valid), 64'd0);
        bus.dhit = 1'b1;
        #1;
        chk("st_stall_hit", 64'(bus.stall), 64'd0);
        exp_q.push_back(mk_wb(1'b1, 5'd0, 1'b0, 32'h0));
        @(negedge CLK); idle();
        bus.dhit = 1'b0;
        chk("st_dwen_drop", 64'(bus.dWEN),      64'd0);
        chk("st_out_valid", 64'(bus.out_valid), 64'd1);
        chk("hlt_stall_a",  64'(bus.stall),     64'd1);
        @(negedge CLK);
        chk("hlt_out_valid", 64'(bus.out_valid), 64'd1);
        chk("hlt_stall_b",   64'(bus.stall),     64'd1);
        op = '0; op.aluOut = 32'h66; op.RegWr = 1'b1; op.MemRd = 1'b1;
        drive(op); bus.dhit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("hlt_stall_hold", 64'(bus.stall),     64'd1);
            chk("hlt_no_out",     64'(bus.out_valid), 64'd0);
            chk("hlt_no_dren",    64'(bus.dREN),      64'd0);
            chk("hlt_no_dwen",    64'(bus.dWEN),      64'd0);
        end
        idle(); bus.dhit = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("hlt_rst_stall", 64'(bus.stall), 64'd0);
        op = '0; op.aluOut = 32'hAB; op.RegWr = 1'b1; op.wsel = 5'd1;
        drive(op); exp_q.push_back(mk_wb(1'b0, 5'd1, 1'b1, 32'hAB));
        @(negedge CLK); idle();
        chk("hlt_rst_op", 64'(bus.out_valid), 64'd1);
        repeat (2) @(negedge CLK);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  in  1  exec result present on in.
REQ-005 SHALL have port in  in  exec_mem_t  exec result (halt, wsel, RegWr, MemToReg, WrLinkReg, MemRd, MemWr, PCSrc, aluOut, zero, rdat1, rdat2, b_addr, j_addr, pc, pred_taken).
REQ-006 SHALL have port dhit  in  1  data-cache completion for the current request.
REQ-007 SHALL have port dmemload  in  DATA_W  load data, valid when dhit.
REQ-008 SHALL have ports dREN / dWEN  out  1 each  registered read / write request.
REQ-009 SHALL have ports dmemaddr / dmemstore  out  DATA_W each  registered address (aluOut) and store data (rdat2).
REQ-010 SHALL have port stall  out  1  upstream must hold when high.
REQ-011 SHALL have ports flush  out  1, npc  out  DATA_W  one-cycle redirect and its target.
REQ-012 SHALL have ports bp_upd  out  1, bp_pc  out  DATA_W, bp_taken  out  1  predictor update.
REQ-013 SHALL have ports out_valid  out  1, out  out  mem_wb_t  (halt, wsel, RegWr, wdat) to writeback.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, HALTED.
REQ-015 SHALL accept when in_valid && !flush && (IDLE || (ACCESS && dhit)).
REQ-016 SHALL drive stall = (ACCESS && !dhit) || HALTED.
REQ-017 On accepting MemRd or MemWr: next cycle ACCESS, dREN=MemRd, dWEN=MemWr, dmemaddr=aluOut, dmemstore=rdat2, held until dhit.
REQ-018 In ACCESS with dhit: drop dREN/dWEN next cycle, register result, return to IDLE unless a new op is accepted the same cycle.
REQ-019 A non-memory op SHALL produce out_valid exactly one cycle after acceptance; a memory op exactly one cycle after dhit.
REQ-020 SHALL form wdat = MemToReg ? dmemload : WrLinkReg ? pc+4 : aluOut (pc+4 modulo 2^DATA_W).
REQ-021 out_valid SHALL be a one-cycle pulse per completed op; out is held otherwise.
REQ-022 SHALL resolve PCSrc per pcsrc_t: SEQ not taken; BEQ taken iff zero; BNE taken iff !zero; JUMP target j_addr; JR target rdat1; branch target b_addr.
REQ-023 Redirect SHALL occur for JUMP/JR always and for BEQ/BNE iff taken != pred_taken; npc = taken ? target : pc+4.
REQ-024 flush/npc SHALL be registered, high exactly the cycle after acceptance; in_valid during that cycle SHALL be dropped.
REQ-025 bp_upd SHALL pulse the cycle after any BEQ/BNE acceptance, with bp_pc=pc, bp_taken=taken, regardless of mispredict.
REQ-026 An accepted halt SHALL produce out_valid with out.halt=1 next cycle and enter HALTED.
REQ-027 HALTED SHALL be exited only by RST; it issues no requests and accepts nothing.

Reset
REQ-028 With RST high at an edge: state IDLE; dREN, dWEN, stall, flush, bp_upd, bp_taken, out_valid = 0; dmemaddr, dmemstore, npc, bp_pc, out = 0.
REQ-029 RST during ACCESS SHALL abandon the request; dREN/dWEN low the cycle after the reset edge; later dhit ignored.

Structure
REQ-030 Shared package cpu_types_pkg SHALL hold exec_mem_t, mem_wb_t, pcsrc_t (3-bit: SEQ, BEQ, BNE, JUMP, JR), and the memstage FSM enum.
REQ-031 SHALL instantiate one sub-module branch_resolve (combinational taken/target/mispredict); all state stays in mem_stage.

Verification
REQ-032 ALU op aluOut=0x10, RegWr, wsel=5 -> next cycle out_valid=1, wdat=0x10, wsel=5; stall never high.
REQ-033 Load aluOut=0x100, dhit after 3 ACCESS cycles, dmemload=0xDEADBEEF -> dREN=1 for 3 cycles, stall=1 for 2, wdat=0xDEADBEEF one cycle after dhit.
REQ-034 BEQ zero=1, pred_taken=0, b_addr=0x40 -> flush=1, npc=0x40, bp_upd=1, bp_taken=1; in_valid in flush cycle dropped.
REQ-035 JAL pc=0x20, j_addr=0x80 -> flush=1, npc=0x80, wdat=0x24; BNE zero=1, pred_taken=0 -> no flush, bp_upd=1.
REQ-036 Store then halt back-to-back -> dWEN held to dhit; halt out_valid after store; HALTED, stall=1 until RST.
REQ-037 RST asserted in ACCESS mid-load -> dREN=0 next cycle, no out_valid, next op accepted normally.
